// File: rtl/snake_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl_if
// Bundles the control-side signals of the snake game sequencer.
//   master : the sequencer itself (consumes buttons/events, drives control)
//   slave  : the surrounding datapath / stimulus (drives buttons/events)
// Inputs to the sequencer:
//   start, btn_up/down/left/right  synchronous button levels
//   tick                           one-cycle game-tick pulse
//   hit_border, hit_body           head collision this cycle
//   apple_eaten                    one-cycle pulse, head reached apple
// Outputs from the sequencer:
//   state[1:0]  0=IDLE 1=INIT 2=PLAY 3=OVER
//   dir[1:0]    0=up 1=down 2=left 3=right
//   step, grow  one-cycle pulses (grow only together with step)
//   reinit      high while in INIT
//   game_over   high while in OVER
//   score_tens, score_ones  BCD score
// ---------------------------------------------------------------------------
interface snake_game_ctrl_if;
    logic       start;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       tick;
    logic       hit_border;
    logic       hit_body;
    logic       apple_eaten;
    logic [1:0] state;
    logic [1:0] dir;
    logic       step;
    logic       grow;
    logic       reinit;
    logic       game_over;
    logic [3:0] score_tens;
    logic [3:0] score_ones;

    modport master (
        input  start, btn_up, btn_down, btn_left, btn_right,
        input  tick, hit_border, hit_body, apple_eaten,
        output state, dir, step, grow, reinit, game_over,
        output score_tens, score_ones
    );

    modport slave (
        output start, btn_up, btn_down, btn_left, btn_right,
        output tick, hit_border, hit_body, apple_eaten,
        input  state, dir, step, grow, reinit, game_over,
        input  score_tens, score_ones
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl
// Game sequencer for the snake VGA design, clocked by the pixel clock.
// Turns start/direction buttons, game ticks and collision/apple events into
// registered control for the snake datapath: state, heading, step/grow
// pulses, reinit, game_over and a saturating BCD score.
// Ports:
//   VGA_clk  pixel clock, rising edge
//   reset    asynchronous, active-high
//   bus      snake_game_ctrl_if.master (see interface file)
// ---------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int INIT_CYCLES   = 4,
    parameter int INIT_DIV      = 8,
    parameter int MIN_DIV       = 2,
    parameter int SPEEDUP_EVERY = 5
) (
    input  logic                  VGA_clk,
    input  logic                  reset,
    snake_game_ctrl_if.master     bus
);

    localparam logic [3:0] LP_INIT_LAST  = 4'(INIT_CYCLES - 1);
    localparam logic [3:0] LP_INIT_DIV   = 4'(INIT_DIV);
    localparam logic [3:0] LP_MIN_DIV    = 4'(MIN_DIV);
    localparam logic [3:0] LP_APPLE_LAST = 4'(SPEEDUP_EVERY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_PLAY = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       w_init_entry;

    logic       r_start_q;
    logic       r_armed;
    logic [3:0] r_init_cnt;
    logic [3:0] r_tick_cnt;
    logic [3:0] r_div;        // divider target, lowered by speed-ups
    logic [3:0] r_div_act;    // divider in force, reloaded only on a wrap
    logic [3:0] r_apple_cnt;
    logic [3:0] r_tens, r_ones;
    logic [1:0] r_dir, r_pend;
    logic       r_grow_pend;
    logic       r_step, r_grow;

    logic       w_start_rise;
    logic       w_hit;
    logic       w_play_ok;
    logic       w_apple;
    logic       w_wrap;
    logic       w_req_vld;
    logic [1:0] w_req;
    logic [1:0] w_pend_nxt;
    logic [3:0] w_div_nxt;
    logic [3:0] w_tens_nxt, w_ones_nxt;

    // r_armed masks the first cycle after reset so a start button held
    // through reset release is not taken as a fresh press.
    assign w_start_rise = bus.start & ~r_start_q & r_armed;
    assign w_hit        = bus.hit_border | bus.hit_body;
    // A collision cancels everything else PLAY would do that cycle.
    assign w_play_ok    = (r_state == S_PLAY) & ~w_hit;
    assign w_apple      = w_play_ok & bus.apple_eaten;
    assign w_wrap       = w_play_ok & bus.tick & (r_tick_cnt == r_div_act - 4'd1);

    // ---------------- FSM ----------------
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_init_entry = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_rise) w_state_nxt = S_INIT;
            S_INIT: if (r_init_cnt == LP_INIT_LAST) w_state_nxt = S_PLAY;
            S_PLAY: if (w_hit) w_state_nxt = S_OVER;
            S_OVER: if (w_start_rise) w_state_nxt = S_INIT;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt == S_INIT && r_state != S_INIT) w_init_entry = 1'b1;
    end

    // ---------------- heading request ----------------
    // Highest-priority pressed button wins; a reversal of the current
    // heading is dropped outright rather than falling back to a lower one.
    always_comb begin
        w_req_vld = 1'b1;
        w_req     = r_pend;
        if      (bus.btn_up)    w_req = 2'd0;
        else if (bus.btn_down)  w_req = 2'd1;
        else if (bus.btn_left)  w_req = 2'd2;
        else if (bus.btn_right) w_req = 2'd3;
        else                    w_req_vld = 1'b0;
        w_pend_nxt = (w_req_vld && (w_req != (r_dir ^ 2'b01))) ? w_req : r_pend;
    end

    // ---------------- speed-up and score ----------------
    always_comb begin
        w_div_nxt = r_div;
        if (w_apple && (r_apple_cnt == LP_APPLE_LAST) && (r_div > LP_MIN_DIV))
            w_div_nxt = r_div - 4'd1;
    end

    always_comb begin
        w_tens_nxt = r_tens;
        w_ones_nxt = r_ones;
        if (!(r_tens == 4'd9 && r_ones == 4'd9)) begin
            if (r_ones == 4'd9) begin
                w_ones_nxt = 4'd0;
                w_tens_nxt = r_tens + 4'd1;
            end else begin
                w_ones_nxt = r_ones + 4'd1;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            r_start_q   <= 1'b0;
            r_armed     <= 1'b0;
            r_init_cnt  <= 4'd0;
            r_tick_cnt  <= 4'd0;
            r_div       <= LP_INIT_DIV;
            r_div_act   <= LP_INIT_DIV;
            r_apple_cnt <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_dir       <= 2'd3;
            r_pend      <= 2'd3;
            r_grow_pend <= 1'b0;
            r_step      <= 1'b0;
            r_grow      <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            r_armed   <= 1'b1;
            r_step    <= 1'b0;
            r_grow    <= 1'b0;
            if (w_init_entry) begin
                r_init_cnt  <= 4'd0;
                r_tick_cnt  <= 4'd0;
                r_div       <= LP_INIT_DIV;
                r_div_act   <= LP_INIT_DIV;
                r_apple_cnt <= 4'd0;
                r_tens      <= 4'd0;
                r_ones      <= 4'd0;
                r_dir       <= 2'd3;
                r_pend      <= 2'd3;
                r_grow_pend <= 1'b0;
            end else begin
                if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 4'd1;
                if (w_play_ok) begin
                    r_pend <= w_pend_nxt;
                    r_div  <= w_div_nxt;
                    if (w_apple) begin
                        r_apple_cnt <= (r_apple_cnt == LP_APPLE_LAST) ? 4'd0 : r_apple_cnt + 4'd1;
                        r_tens      <= w_tens_nxt;
                        r_ones      <= w_ones_nxt;
                    end
                    if (w_wrap) begin
                        // An apple in the wrap cycle still rides on this step.
                        r_tick_cnt  <= 4'd0;
                        r_step      <= 1'b1;
                        r_grow      <= r_grow_pend | w_apple;
                        r_grow_pend <= 1'b0;
                        r_dir       <= w_pend_nxt;
                        r_div_act   <= w_div_nxt;
                    end else begin
                        if (bus.tick) r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_apple)  r_grow_pend <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.dir        = r_dir;
    assign bus.step       = r_step;
    assign bus.grow       = r_grow;
    assign bus.reinit     = (r_state == S_INIT);
    assign bus.game_over  = (r_state == S_OVER);
    assign bus.score_tens = r_tens;
    assign bus.score_ones = r_ones;

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;
    localparam int INIT_CYCLES   = 4;
    localparam int INIT_DIV      = 8;
    localparam int MIN_DIV       = 2;
    localparam int SPEEDUP_EVERY = 5;

    logic VGA_clk = 1'b0;
    logic reset   = 1'b1;

    snake_game_ctrl_if bus();

    snake_game_ctrl #(
        .INIT_CYCLES(INIT_CYCLES), .INIT_DIV(INIT_DIV),
        .MIN_DIV(MIN_DIV), .SPEEDUP_EVERY(SPEEDUP_EVERY)
    ) dut (
        .VGA_clk(VGA_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 VGA_clk = ~VGA_clk;

    int cmp_tests = 0, cmp_fail = 0;
    int chk_tests = 0, chk_fail = 0;
    int n_steps_seen = 0;
    bit cmp_en = 1'b0;

    // ---------------- behavioural model ----------------
    int m_st, m_dir, m_pend, m_score, m_cnt, m_div, m_div_act, m_gp, m_ac, m_icnt;
    bit m_prev, m_step, m_grow;

    task automatic m_reset();
        m_st = 0; m_dir = 3; m_pend = 3; m_score = 0; m_cnt = 0;
        m_div = INIT_DIV; m_div_act = INIT_DIV; m_gp = 0; m_ac = 0; m_icnt = 0;
        m_prev = 1'b1;  // a level already high at reset release is not a press
        m_step = 1'b0; m_grow = 1'b0;
    endtask

    task automatic m_enter_init();
        m_st = 1; m_icnt = 0; m_score = 0; m_dir = 3; m_pend = 3;
        m_div = INIT_DIV; m_div_act = INIT_DIV; m_cnt = 0; m_gp = 0; m_ac = 0;
    endtask

    task automatic m_cycle();
        bit rise;
        int req;
        rise   = bus.start && !m_prev;
        m_prev = bus.start;
        m_step = 1'b0;
        m_grow = 1'b0;
        case (m_st)
            0: if (rise) m_enter_init();
            1: begin
                m_icnt++;
                if (m_icnt == INIT_CYCLES) m_st = 2;
            end
            2: begin
                if (bus.hit_border || bus.hit_body) m_st = 3;
                else begin
                    req = bus.btn_up ? 0 : bus.btn_down ? 1 : bus.btn_left ? 2 : bus.btn_right ? 3 : -1;
                    if (req >= 0 && req != (m_dir ^ 1)) m_pend = req;
                    if (bus.apple_eaten) begin
                        m_gp = 1;
                        if (m_score < 99) m_score++;
                        m_ac++;
                        if (m_ac == SPEEDUP_EVERY) begin
                            m_ac = 0;
                            if (m_div > MIN_DIV) m_div--;
                        end
                    end
                    if (bus.tick) begin
                        if (m_cnt == m_div_act - 1) begin
                            m_cnt = 0; m_step = 1'b1; m_grow = (m_gp != 0); m_gp = 0;
                            m_dir = m_pend; m_div_act = m_div;
                        end else m_cnt++;
                    end
                end
            end
            default: if (rise) m_enter_init();
        endcase
    endtask

    always @(posedge VGA_clk or posedge reset) begin
        if (reset) m_reset();
        else       m_cycle();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge VGA_clk) begin
        if (cmp_en) begin
            cmp_tests++;
            if (int'(bus.state) != m_st || int'(bus.dir) != m_dir || bus.step != m_step ||
                bus.grow != m_grow || bus.reinit != (m_st == 1) || bus.game_over != (m_st == 3) ||
                int'(bus.score_tens) != m_score / 10 || int'(bus.score_ones) != m_score % 10) begin
                cmp_fail++;
                $display("FAIL model_cmp t=%0t got st=%0d dir=%0d step=%0b grow=%0b reinit=%0b go=%0b score=%0d%0d exp st=%0d dir=%0d step=%0b grow=%0b score=%0d",
                         $time, bus.state, bus.dir, bus.step, bus.grow, bus.reinit, bus.game_over,
                         bus.score_tens, bus.score_ones, m_st, m_dir, m_step, m_grow, m_score);
            end
        end
    end

    always @(negedge VGA_clk) if (bus.step === 1'b1) n_steps_seen++;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        chk_tests++;
        if (act != exp) begin
            chk_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge VGA_clk);
        #2;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1; nxt(); bus.start = 1'b0;
    endtask

    task automatic apple();
        bus.apple_eaten = 1'b1; nxt(); bus.apple_eaten = 1'b0; nxt();
    endtask

    task automatic wait_play();
        int k;
        k = 0;
        while (bus.state != 2'd2 && k < 30) begin nxt(); k++; end
        if (k >= 30) chk("wait_play_timeout", int'(bus.state), 2);
    endtask

    // Pulse ticks until a step appears; returns tick count and the grow seen with it.
    task automatic ticks_to_step(output int n, output bit g);
        bit done;
        n = 0; g = 1'b0; done = 1'b0;
        while (!done && n < 40) begin
            bus.tick = 1'b1; nxt(); bus.tick = 1'b0; n++;
            if (bus.step) begin g = bus.grow; done = 1'b1; end
            nxt();
        end
        if (!done) begin
            chk("step_timeout", n, -1);
            n = -1;
        end
    endtask

    int n, idx[$], s0;
    bit g;

    initial begin
        bus.start = 1'b1; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.tick = 0; bus.hit_border = 0; bus.hit_body = 0; bus.apple_eaten = 0;
        reset = 1'b1;
        repeat (3) @(posedge VGA_clk);
        #2;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_dir", int'(bus.dir), 3);
        chk("rst_score", int'({bus.score_tens, bus.score_ones}), 0);
        chk("rst_outs", int'({bus.step, bus.grow, bus.reinit, bus.game_over}), 0);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // start held through reset release: no edge
        repeat (5) nxt();
        chk("start_held_idle", int'(bus.state), 0);
        bus.start = 1'b0; nxt();
        start_pulse();
        chk("init_entry", int'({bus.state, bus.reinit}), 3);  // state 1, reinit 1
        repeat (3) begin nxt(); chk("init_hold", int'(bus.state), 1); end
        nxt();
        chk("play_entry", int'(bus.state), 2);
        chk("play_dir", int'(bus.dir), 3);
        chk("play_score", int'({bus.score_tens, bus.score_ones}), 0);

        // 16 ticks -> steps after tick 8 and 16
        for (int i = 1; i <= 16; i++) begin
            bus.tick = 1'b1; nxt(); bus.tick = 1'b0;
            if (bus.step) idx.push_back(i);
            nxt();
        end
        chk("step_count16", idx.size(), 2);
        if (idx.size() == 2) begin
            chk("step_at_8", idx[0], 8);
            chk("step_at_16", idx[1], 16);
        end
        chk("dir_still_right", int'(bus.dir), 3);

        // left rejected, up accepted at next step
        bus.btn_left = 1; nxt(); bus.btn_left = 0;
        bus.btn_up = 1; nxt(); bus.btn_up = 0;
        chk("dir_before_step", int'(bus.dir), 3);
        ticks_to_step(n, g);
        chk("dir_up_gap", n, 8);
        chk("dir_up", int'(bus.dir), 0);
        // up+right together: up wins (right would have been legal)
        bus.btn_up = 1; bus.btn_right = 1; nxt(); bus.btn_up = 0; bus.btn_right = 0;
        ticks_to_step(n, g);
        chk("dir_up_prio", int'(bus.dir), 0);

        // 5 apples, each followed by a growing step
        for (int k = 1; k <= 5; k++) begin
            apple();
            chk("score_inc", int'({bus.score_tens, bus.score_ones}), k);
            ticks_to_step(n, g);
            chk("grow_with_step", int'(g), 1);
        end
        ticks_to_step(n, g);
        chk("gap_after_5", n, 7);
        chk("no_grow", int'(g), 0);

        // saturate score and divider
        repeat (100) apple();
        chk("score_sat", int'({bus.score_tens, bus.score_ones}), 'h99);
        ticks_to_step(n, g);
        chk("gap_reload", n, 7);
        ticks_to_step(n, g);
        chk("gap_min", n, 2);

        // collision together with apple at score 12
        bus.hit_body = 1; nxt(); bus.hit_body = 0;
        chk("over_state", int'(bus.state), 3);
        start_pulse(); wait_play();
        repeat (12) apple();
        chk("score_12", int'({bus.score_tens, bus.score_ones}), 'h12);
        bus.apple_eaten = 1; bus.hit_body = 1; nxt(); bus.apple_eaten = 0; bus.hit_body = 0;
        chk("hit_apple_over", int'(bus.state), 3);
        chk("hit_apple_score", int'({bus.score_tens, bus.score_ones}), 'h12);
        chk("hit_apple_go", int'(bus.game_over), 1);
        s0 = n_steps_seen;
        repeat (10) begin bus.tick = 1; nxt(); bus.tick = 0; nxt(); end
        chk("no_step_over", n_steps_seen - s0, 0);
        start_pulse();
        chk("restart_init", int'(bus.state), 1);
        chk("restart_score", int'({bus.score_tens, bus.score_ones}), 0);
        wait_play();

        // async reset mid-game at score 34
        repeat (34) apple();
        chk("score_34", int'({bus.score_tens, bus.score_ones}), 'h34);
        bus.btn_down = 1; nxt(); bus.btn_down = 0;
        ticks_to_step(n, g);
        bus.start = 1; reset = 1'b1; #1;
        chk("arst_state", int'(bus.state), 0);
        chk("arst_dir", int'(bus.dir), 3);
        chk("arst_score", int'({bus.score_tens, bus.score_ones}), 0);
        chk("arst_outs", int'({bus.step, bus.grow, bus.reinit, bus.game_over}), 0);
        repeat (2) nxt();
        reset = 1'b0;
        repeat (3) nxt();
        chk("post_rst_idle", int'(bus.state), 0);
        bus.start = 0; nxt();

        // randomized phase, checked by the model every cycle
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 29) == 0) bus.start = ~bus.start;
            bus.btn_up      = ($urandom_range(0, 7) == 0);
            bus.btn_down    = ($urandom_range(0, 7) == 0);
            bus.btn_left    = ($urandom_range(0, 7) == 0);
            bus.btn_right   = ($urandom_range(0, 7) == 0);
            bus.tick        = ($urandom_range(0, 1) == 0);
            bus.apple_eaten = ($urandom_range(0, 9) == 0);
            bus.hit_border  = ($urandom_range(0, 299) == 0);
            bus.hit_body    = ($urandom_range(0, 299) == 0);
            reset           = ($urandom_range(0, 1999) == 0);
            nxt();
        end
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.tick = 0; bus.apple_eaten = 0; bus.hit_border = 0; bus.hit_body = 0; reset = 0;
        repeat (3) nxt();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", cmp_tests + chk_tests, cmp_fail + chk_fail);
        $finish;
    end
endmodule
